// File: rtl/mem_data_controller_pkg.sv
// Shared definitions for the MEM-stage data memory controller.
package mem_data_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Byte write-enable masks, big-endian: bit3 covers data[31:24].
    localparam logic [3:0] LANE_WORD    = 4'b1111;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_BYTE0   = 4'b1000;

    // Byte at address offset a lives in lane 3-a.
    function automatic logic [3:0] byte_lane(input logic [1:0] a);
        return LANE_BYTE0 >> a;
    endfunction

endpackage

// File: rtl/mem_lane_format.sv
// Combinational load formatting: picks the byte/half from a big-endian
// word and sign- or zero-extends it. Word accesses pass straight through.
module mem_lane_format (
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic        is_byte,
    input  logic        is_half,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [1:0]  lane;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    assign lane  = 2'd3 - addr_lo;
    assign sel_b = word[{lane, 3'b000} +: 8];
    assign sel_h = addr_lo[1] ? word[15:0] : word[31:16];

    // Extract and extend according to access size.
    always_comb begin
        data = word;
        if (is_byte)
            data = {{24{sign_ext & sel_b[7]}}, sel_b};
        else if (is_half)
            data = {{16{sign_ext & sel_h[15]}}, sel_h};
    end

endmodule

// File: rtl/mem_data_controller.sv
// MEM-stage data memory controller: request/ready handshake, stall
// generation, big-endian lane steering, address errors and LL/SC link.
module mem_data_controller
    import mem_data_controller_pkg::*;
#(
    parameter int ADDR_W = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       MEM_Address,
    input  logic [31:0]       MEM_WriteData,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic              MEM_Byte,
    input  logic              MEM_Half,
    input  logic              MEM_SignExtend,
    input  logic              MEM_LLSC,
    input  logic              M_Stall,
    input  logic              Eret,
    output logic [31:0]       ReadData,
    output logic              M_Stall_Controller,
    output logic              ExcAdEL,
    output logic              ExcAdES,
    output logic [ADDR_W-1:0] DataMem_Address,
    output logic              DataMem_Read,
    output logic [3:0]        DataMem_Write,
    output logic [31:0]       DataMem_Out,
    input  logic [31:0]       DataMem_In,
    input  logic              DataMem_Ready
);

    mem_state_e  state, state_nxt;
    logic [31:0] held_data;
    logic        llsc_valid;
    logic [29:0] llsc_addr;

    logic [29:0] word_addr;
    logic        aligned, is_sc, sc_fail, access_valid, req_en, complete;
    logic [3:0]  wr_lanes;
    logic [31:0] wr_data, fmt_data;

    assign word_addr = MEM_Address[31:2];
    assign aligned   = MEM_Byte | (MEM_Half & ~MEM_Address[0]) |
                       (~MEM_Byte & ~MEM_Half & (MEM_Address[1:0] == 2'b00));
    assign is_sc     = MEM_MemWrite & MEM_LLSC;
    assign sc_fail   = is_sc & ~(llsc_valid & (llsc_addr == word_addr));
    assign access_valid = (MEM_MemRead | MEM_MemWrite) & aligned & ~sc_fail;

    // Reset gates the request combinationally so the bus goes quiet at once,
    // even while the pipeline still presents the old MEM controls.
    assign req_en   = reset & access_valid & (state != DONE);
    assign complete = req_en & DataMem_Ready;

    assign ExcAdEL = MEM_MemRead  & ~aligned;
    assign ExcAdES = MEM_MemWrite & ~aligned;

    // Never a function of M_Stall, which already folds this signal in.
    assign M_Stall_Controller = req_en & ~DataMem_Ready;

    // Store lane steering and data replication.
    always_comb begin
        wr_lanes = LANE_WORD;
        wr_data  = MEM_WriteData;
        if (MEM_Byte) begin
            wr_lanes = byte_lane(MEM_Address[1:0]);
            wr_data  = {4{MEM_WriteData[7:0]}};
        end else if (MEM_Half) begin
            wr_lanes = MEM_Address[1] ? LANE_HALF_LO : LANE_HALF_HI;
            wr_data  = {2{MEM_WriteData[15:0]}};
        end
    end

    assign DataMem_Read    = req_en & MEM_MemRead;
    assign DataMem_Write   = (req_en & MEM_MemWrite) ? wr_lanes : 4'b0000;
    assign DataMem_Out     = (req_en & MEM_MemWrite) ? wr_data  : 32'h0;
    assign DataMem_Address = req_en ? ADDR_W'(word_addr) : '0;

    mem_lane_format u_fmt (
        .word     (DataMem_In),
        .addr_lo  (MEM_Address[1:0]),
        .is_byte  (MEM_Byte),
        .is_half  (MEM_Half),
        .sign_ext (MEM_SignExtend),
        .data     (fmt_data)
    );

    // SC reports success only on the cycle its write completes; a failed SC
    // reads 0 immediately. After completion under stall, the held copy wins.
    always_comb begin
        if (state == DONE)
            ReadData = held_data;
        else if (is_sc)
            ReadData = {31'b0, complete};
        else
            ReadData = fmt_data;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: park in DONE when the access finishes under a foreign stall
    // so the still-present MEM controls do not re-issue it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (access_valid)
                      state_nxt = DataMem_Ready ? (M_Stall ? DONE : IDLE) : BUSY;
            BUSY: if (DataMem_Ready)
                      state_nxt = M_Stall ? DONE : IDLE;
            DONE: if (!M_Stall)
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the result that MEM will see while parked in DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            held_data <= 32'h0;
        else if (complete)
            held_data <= is_sc ? 32'h1 : (MEM_MemRead ? fmt_data : 32'h0);
    end

    // LL/SC link tracking; Eret beats a simultaneous LL.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            llsc_valid <= 1'b0;
            llsc_addr  <= 30'h0;
        end else if (Eret) begin
            llsc_valid <= 1'b0;
        end else if (complete) begin
            if (MEM_MemRead & MEM_LLSC) begin
                llsc_valid <= 1'b1;
                llsc_addr  <= word_addr;
            end else if (MEM_MemWrite & (MEM_LLSC | (word_addr == llsc_addr))) begin
                llsc_valid <= 1'b0;
            end
        end
    end

endmodule
